// File: rtl/sensor_sync_bank_if.sv
//------------------------------------------------------------------------------
// Module   : sensor_sync_bank_if
// Brief    : Sensor inputs, channel select and debounced outputs of sensor_sync_bank.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sensor_sync_bank_if #(
    parameter int N_SENSORS = 6,
    parameter int SEL_W     = 5
);
    logic [N_SENSORS-1:0] S;
    logic [SEL_W-1:0]     Selector;
    logic                 Enable;
    logic                 Clear;
    logic                 Y;
    logic                 Rise;
    logic                 Valid;
    logic [N_SENSORS-1:0] Stable;
    logic [N_SENSORS-1:0] EventFlags;

    modport master (
        output S, Selector, Enable, Clear,
        input  Y, Rise, Valid, Stable, EventFlags
    );

    modport slave (
        input  S, Selector, Enable, Clear,
        output Y, Rise, Valid, Stable, EventFlags
    );
endinterface

`default_nettype wire

// File: rtl/sensor_sync_bank.sv
//------------------------------------------------------------------------------
// Module   : sensor_sync_bank
// Brief    : Per-channel 2-flop sync + debounce, selectable Y/Rise output and
//            optional sticky rise flags (enabled by SYNC_EVENT_LATCH_EN).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sensor_sync_bank #(
    parameter int N_SENSORS       = 6,
    parameter int SEL_W           = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire               Clk,
    input  wire               Reset,
    sensor_sync_bank_if.slave bus
);
    localparam int                 c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SENSORS-1:0] r_sync1;
    logic [N_SENSORS-1:0] r_sync2;
    logic [N_SENSORS-1:0] r_stable;
    logic [N_SENSORS-1:0] r_stable_d;
    logic [N_SENSORS-1:0] w_load;
    logic                 w_valid_nxt;
    logic                 w_sel_lvl;
    logic                 w_sel_lvl_d;
    logic                 r_y;
    logic                 r_rise;
    logic                 r_valid;

    genvar g;
    generate
        for (g = 0; g < N_SENSORS; g = g + 1) begin : g_chan
            logic [c_CNT_W-1:0] r_cnt;

            // Load fires on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
            assign w_load[g] = (r_sync2[g] != r_stable[g]) && (r_cnt == c_LAST);

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_cnt <= '0;
                end else if ((r_sync2[g] == r_stable[g]) || (r_cnt == c_LAST)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
        end else begin
            r_sync1    <= bus.S;
            r_sync2    <= r_sync1;
            r_stable   <= r_stable ^ w_load;
            r_stable_d <= r_stable;
        end
    end

    assign w_valid_nxt = (32'(bus.Selector) < N_SENSORS);

    always_comb begin
        w_sel_lvl   = 1'b0;
        w_sel_lvl_d = 1'b0;
        for (int k = 0; k < N_SENSORS; k++) begin
            if (bus.Selector == SEL_W'(k)) begin
                w_sel_lvl   = r_stable[k];
                w_sel_lvl_d = r_stable_d[k];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_y     <= 1'b0;
            r_rise  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_y     <= bus.Enable & w_valid_nxt & w_sel_lvl;
            r_rise  <= bus.Enable & w_valid_nxt & w_sel_lvl & ~w_sel_lvl_d;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.Y      = r_y;
    assign bus.Rise   = r_rise;
    assign bus.Valid  = r_valid;
    assign bus.Stable = r_stable;

`ifdef SYNC_EVENT_LATCH_EN
    logic [N_SENSORS-1:0] r_flags;

    // A new rising edge wins over a simultaneous Clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= (bus.Clear ? '0 : r_flags) | (w_load & r_sync2);
        end
    end

    assign bus.EventFlags = r_flags;
`else
    logic w_unused_clear;
    assign w_unused_clear = bus.Clear;
    assign bus.EventFlags = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sensor_sync_bank.sv
//------------------------------------------------------------------------------
// Module   : tb_sensor_sync_bank
// Brief    : Scoreboarded bench for sensor_sync_bank (default parameters).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sensor_sync_bank;
    localparam int N = 6;
    localparam int D = 4;
`ifdef SYNC_EVENT_LATCH_EN
    localparam bit c_FLAG_EN = 1'b1;
`else
    localparam bit c_FLAG_EN = 1'b0;
`endif

    typedef struct packed {
        logic         y;
        logic         rise;
        logic         valid;
        logic [N-1:0] stable;
        logic [N-1:0] flags;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_std = '0, m_fl = '0;
    int           m_run[N];
    logic         m_y = 1'b0, m_rise = 1'b0, m_valid = 1'b0;

    sensor_sync_bank_if #(.N_SENSORS(N), .SEL_W(5)) bus ();

    sensor_sync_bank #(
        .N_SENSORS       (N),
        .SEL_W           (5),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Predict the outputs of the coming edge, push them, clock, then compare.
    task automatic step();
        exp_t         e;
        exp_t         got;
        logic [N-1:0] nst;
        logic [N-1:0] setv;
        int           sel;
        logic         lvl, lvl_d;
        if (Reset) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_std = '0; m_fl = '0;
            m_y = 1'b0; m_rise = 1'b0; m_valid = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            sel     = int'(bus.Selector);
            m_valid = (sel < N);
            lvl     = m_valid ? m_st[sel]  : 1'b0;
            lvl_d   = m_valid ? m_std[sel] : 1'b0;
            m_y     = bus.Enable & m_valid & lvl;
            m_rise  = bus.Enable & m_valid & lvl & ~lvl_d;
            nst     = m_st;
            setv    = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] !== m_st[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        nst[i]   = m_s2[i];
                        setv[i]  = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (c_FLAG_EN) m_fl = (bus.Clear ? '0 : m_fl) | setv;
            m_std = m_st;
            m_st  = nst;
            m_s2  = m_s1;
            m_s1  = bus.S;
        end
        e = '{y: m_y, rise: m_rise, valid: m_valid, stable: m_st, flags: m_fl};
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        got = sb_q.pop_front();
        chk("sb_y",      32'(bus.Y),          32'(got.y));
        chk("sb_rise",   32'(bus.Rise),       32'(got.rise));
        chk("sb_valid",  32'(bus.Valid),      32'(got.valid));
        chk("sb_stable", 32'(bus.Stable),     32'(got.stable));
        chk("sb_flags",  32'(bus.EventFlags), 32'(got.flags));
    endtask

    initial begin
        bus.S = '0; bus.Selector = 5'd2; bus.Enable = 1'b1; bus.Clear = 1'b0;
        Reset = 1'b1;
        #1;
        step(); step();
        chk("rst_stable", 32'(bus.Stable), 32'd0);
        chk("rst_y",      32'(bus.Y),      32'd0);
        chk("rst_valid",  32'(bus.Valid),  32'd0);
        chk("rst_flags",  32'(bus.EventFlags), 32'd0);

        // Three-cycle glitch on S[2] must be rejected
        Reset = 1'b0;
        bus.S = 6'b000100;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) bus.S = '0;
            step();
            chk("glitch_stable2", 32'(bus.Stable[2]),     32'd0);
            chk("glitch_y",       32'(bus.Y),             32'd0);
            chk("glitch_rise",    32'(bus.Rise),          32'd0);
            chk("glitch_flag2",   32'(bus.EventFlags[2]), 32'd0);
        end

        // Basic qualification latency after reset
        Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        bus.S = 6'b001110;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 4) chk("lat_stable_e4", 32'(bus.Stable), 32'd0);
            if (k == 5) chk("lat_stable_e5", 32'(bus.Stable), 32'b001110);
            if (k == 5) chk("lat_y_e5",      32'(bus.Y),      32'd0);
            if (k == 6) chk("lat_y_e6",      32'(bus.Y),      32'd1);
            if (k == 6) chk("lat_rise_e6",   32'(bus.Rise),   32'd1);
            if (k == 7) chk("lat_rise_e7",   32'(bus.Rise),   32'd0);
            if (k == 7) chk("lat_y_e7",      32'(bus.Y),      32'd1);
        end

        // Selector out of range, then back to valid channels
        bus.Selector = 5'd6;
        step();
        chk("sel6_valid", 32'(bus.Valid), 32'd0);
        chk("sel6_y",     32'(bus.Y),     32'd0);
        bus.Selector = 5'd0;
        step();
        chk("sel0_valid", 32'(bus.Valid), 32'd1);
        chk("sel0_y",     32'(bus.Y),     32'd0);
        chk("sel0_rise",  32'(bus.Rise),  32'd0);
        bus.Selector = 5'd1;
        step();
        chk("sel1_y",    32'(bus.Y),    32'd1);
        chk("sel1_rise", 32'(bus.Rise), 32'd0);
        bus.Selector = 5'd31;
        step();
        chk("sel31_valid", 32'(bus.Valid), 32'd0);

        // Enable low while a channel qualifies
        bus.Selector = 5'd5;
        bus.Enable   = 1'b0;
        bus.S        = 6'b101110;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("en0_y",    32'(bus.Y),    32'd0);
            chk("en0_rise", 32'(bus.Rise), 32'd0);
        end
        chk("en0_stable5", 32'(bus.Stable[5]),     32'd1);
        chk("en0_flag5",   32'(bus.EventFlags[5]), 32'(c_FLAG_EN));
        bus.Enable = 1'b1;
        step();
        chk("en1_y",    32'(bus.Y),    32'd1);
        chk("en1_rise", 32'(bus.Rise), 32'd0);

        // Clear coinciding with a new rise keeps the flag
        bus.Clear = 1'b1;
        step();
        chk("clr_all", 32'(bus.EventFlags), 32'd0);
        bus.Clear = 1'b0;
        bus.S     = 6'b101100;
        for (int k = 0; k < 7; k++) step();
        chk("s1_low", 32'(bus.Stable[1]), 32'd0);
        bus.S = 6'b101110;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) bus.Clear = 1'b1;
            step();
            if (k == 4) chk("clr_flag1_e4", 32'(bus.EventFlags[1]), 32'd0);
            if (k == 5) chk("clr_flag1_e5", 32'(bus.EventFlags[1]), 32'(c_FLAG_EN));
            if (k == 6) chk("clr_flag1_e6", 32'(bus.EventFlags[1]), 32'd0);
        end
        bus.Clear = 1'b0;

        // Reset in the middle of a debounce discards the count
        bus.S = 6'b111110;
        for (int k = 0; k < 3; k++) step();
        Reset = 1'b1;
        step();
        chk("midrst_stable", 32'(bus.Stable), 32'd0);
        chk("midrst_y",      32'(bus.Y),      32'd0);
        Reset = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            step();
            if (r == 5) chk("midrst_s4_r5", 32'(bus.Stable[4]), 32'd0);
            if (r == 6) chk("midrst_s4_r6", 32'(bus.Stable[4]), 32'd1);
        end
        for (int k = 0; k < 3; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
